// File: rtl/pipeline_stage_elastic.sv
// Elastic pipeline register with optional skid entry.
// Flush loads a NOP control word; counters track bubbles and kills.
module pipeline_stage_elastic #(
  parameter int                 DATA_W   = 32,
  parameter int                 CTRL_W   = 16,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
  parameter int                 SKID     = 1,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              consume;
  logic              main_free;

  // Handshake qualifiers for this cycle.
  always_comb begin
    accept    = in_valid & in_ready;
    consume   = out_valid & out_ready;
    main_free = !out_valid | out_ready;
  end

  // With a skid, in_ready is a pure register output.
  if (SKID != 0) begin : g_skid_rdy
    assign in_ready = !skid_valid;
  end else begin : g_flat_rdy
    assign in_ready = !out_valid | out_ready;
  end

  // Main and skid entries; skid always drains into main first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_ctrl   <= CTRL_NOP;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= CTRL_NOP;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_ctrl   <= CTRL_NOP;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= CTRL_NOP;
      skid_data  <= '0;
    end else if (main_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_ctrl   <= skid_ctrl;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_ctrl  <= in_ctrl;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
        out_ctrl  <= CTRL_NOP;
      end
    end else if (accept && (SKID != 0)) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
    end
  end

  // Saturating bubble and flush-kill counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (out_ready && !out_valid &&
          bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + CNT_ONE;
      if (flush && (out_valid || skid_valid) &&
          flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  logic unused_consume;
  assign unused_consume = consume;

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// Scoreboard bench for pipeline_stage_elastic.
// Runs a SKID=1 and a SKID=0 instance on the same stimulus.
module tb_pipeline_stage_elastic;

  localparam logic [15:0] NOP = 16'h0013;
  localparam int CMAX = 15;

  typedef struct packed {
    logic [15:0] c;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_ctrl = '0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        ir[2];
  logic        ov[2];
  logic [15:0] oc[2];
  logic [31:0] od[2];
  logic [3:0]  bc[2];
  logic [3:0]  fc[2];

  int errors = 0;
  int checks = 0;
  bit run = 1'b0;
  int seq = 100;

  ent_t        sb0[$];
  ent_t        sb1[$];
  ent_t        q[$];
  int          bub[2];
  int          fls[2];
  logic [31:0] lastd[2];

  always #5 clk = ~clk;

  pipeline_stage_elastic #(
    .DATA_W(32), .CTRL_W(16), .CTRL_NOP(NOP),
    .SKID(1), .CNT_W(4)
  ) dut_s (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_ctrl(oc[0]), .out_data(od[0]),
    .bubble_cnt(bc[0]), .flush_cnt(fc[0])
  );

  pipeline_stage_elastic #(
    .DATA_W(32), .CTRL_W(16), .CTRL_NOP(NOP),
    .SKID(0), .CNT_W(4)
  ) dut_f (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_ctrl(oc[1]), .out_data(od[1]),
    .bubble_cnt(bc[1]), .flush_cnt(fc[1])
  );

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s dut%0d t=%0t got=%h want=%h",
                 nm, k, $time, act, exp);
    end
  endtask

  // Model: queue of held entries in acceptance order.
  always @(negedge clk) begin
    if (run && !rst) begin
      for (int k = 0; k < 2; k++) begin
        logic ev, er, cons, acc;
        logic [15:0] ec;
        logic [31:0] ed;
        if (k == 0) q = sb0; else q = sb1;
        ev = q.size() > 0;
        if (k == 0) er = q.size() < 2;
        else        er = (q.size() == 0) || out_ready;
        ec = ev ? q[0].c : NOP;
        ed = ev ? q[0].d : lastd[k];
        chk("out_valid", k, 32'(ov[k]), 32'(ev));
        chk("in_ready", k, 32'(ir[k]), 32'(er));
        chk("out_ctrl", k, 32'(oc[k]), 32'(ec));
        chk("out_data", k, od[k], ed);
        chk("bubble_cnt", k, 32'(bc[k]), 32'(bub[k]));
        chk("flush_cnt", k, 32'(fc[k]), 32'(fls[k]));
        cons = ev && out_ready;
        acc  = in_valid && er;
        if (out_ready && !ev && bub[k] < CMAX)
          bub[k]++;
        if (cons) void'(q.pop_front());
        if (flush) begin
          if (ev && fls[k] < CMAX) fls[k]++;
          q.delete();
          lastd[k] = '0;
        end else begin
          if (acc) q.push_back({in_ctrl, in_data});
          if (q.size() > 0) lastd[k] = q[0].d;
        end
        if (k == 0) sb0 = q; else sb1 = q;
      end
    end
  end

  task automatic drive(input logic iv,
                       input logic [31:0] d,
                       input logic ordy,
                       input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = {d[7:0], ~d[7:0]};
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, 32'(ov[k]), 32'd0);
      chk("rst_ctrl", k, 32'(oc[k]), 32'(NOP));
      chk("rst_data", k, od[k], 32'd0);
      chk("rst_bub", k, 32'(bc[k]), 32'd0);
      chk("rst_fls", k, 32'(fc[k]), 32'd0);
      bub[k] = 0;
      fls[k] = 0;
      lastd[k] = '0;
    end
    sb0.delete();
    sb1.delete();
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run = 1'b1;
  endtask

  initial begin
    do_reset();
    // streaming 1..8
    for (int i = 1; i <= 8; i++) drive(1, i, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    // backpressure A, B
    drive(1, 32'hA, 0, 0);
    drive(1, 32'hB, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
    // flush a full stage while C is offered
    drive(1, 32'hC1, 0, 0);
    drive(1, 32'hC2, 0, 0);
    drive(1, 32'hC, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    // async reset with entries held
    drive(1, 32'h51, 0, 0);
    drive(1, 32'h52, 0, 0);
    drive(0, 0, 0, 0);
    do_reset();
    // bubble saturation: 2^4+3 cycles
    for (int i = 0; i < 19; i++) drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      chk("bub_sat", k, 32'(bc[k]), 32'd15);
    do_reset();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      seq++;
      drive(1'($urandom_range(0, 3) != 0), seq,
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 31) == 0));
    end
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    @(negedge clk);
    #1;
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
